muldiv_unit: RTL and testbench

Multi-cycle unsigned multiply/divide execution unit for the 16-bit CPU. It takes its operands from the register file read ports (ReadRS/ReadRT) and iterates one bit per clock. It then produces a one-cycle write-back (RegWrite, RD, WriteData) that drives the register file write port directly. The Busy output lets the control unit stall issue while an operation is in flight.

---
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide unit, one bit per clock.
// Single write-back strobe feeds the register file write port.
module muldiv_unit #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 2
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [1:0]        Op,
   input  logic [WIDTH-1:0]  OperandA,
   input  logic [WIDTH-1:0]  OperandB,
   input  logic [ADDR_W-1:0] DestIn,
   output logic              Busy,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] RD,
   output logic [WIDTH-1:0]  WriteData,
   output logic              DivByZero
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [ADDR_W-1:0]  dest_q, dest_d;
   logic [ADDR_W-1:0]  rd_q, rd_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   wdata_q, wdata_d;
   logic               dz_q, dz_d;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_nxt;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] div_nxt;
   logic [2*WIDTH-1:0] acc_nxt;

   // acc holds {partial product, multiplier} or {remainder, quotient}
   always_comb begin
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
      rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      diff    = rem_sh - {1'b0, opnd_q};
      if (diff[WIDTH]) begin
         div_nxt = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         div_nxt = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
      acc_nxt = op_q[1] ? div_nxt : mul_nxt;
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      dest_d  = dest_q;
      rd_d    = rd_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      dz_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (Start) begin
               op_d   = Op;
               dest_d = DestIn;
               cnt_d  = '0;
               if (Op[1] && (OperandB == '0)) begin
                  state_d = S_DONE;
                  rd_d    = DestIn;
                  wdata_d = Op[0] ? OperandA : '1;
                  dz_d    = 1'b1;
                  acc_d   = '0;
                  opnd_d  = '0;
               end else begin
                  state_d = S_RUN;
                  opnd_d  = Op[1] ? OperandB : OperandA;
                  acc_d   = {{WIDTH{1'b0}},
                             (Op[1] ? OperandA : OperandB)};
               end
            end
         end
         S_RUN: begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_DONE;
               rd_d    = dest_q;
               wdata_d = op_q[0] ? acc_nxt[2*WIDTH-1:WIDTH]
                                 : acc_nxt[WIDTH-1:0];
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         dest_q  <= '0;
         rd_q    <= '0;
         opnd_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         wdata_q <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         dest_q  <= dest_d;
         rd_q    <= rd_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         wdata_q <= wdata_d;
         dz_q    <= dz_d;
      end
   end

   assign Busy      = (state_q != S_IDLE);
   assign RegWrite  = (state_q == S_DONE);
   assign RD        = rd_q;
   assign WriteData = wdata_q;
   assign DivByZero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results,
// write-back latency, Start collisions and mid-op reset.
module tb_muldiv_unit;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Start;
   logic [1:0]  Op;
   logic [15:0] OperandA;
   logic [15:0] OperandB;
   logic [1:0]  DestIn;
   logic        Busy;
   logic        RegWrite;
   logic [1:0]  RD;
   logic [15:0] WriteData;
   logic        DivByZero;

   int n_pass  = 0;
   int n_total = 0;

   muldiv_unit #(.WIDTH(16), .ADDR_W(2)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Start     (Start),
      .Op        (Op),
      .OperandA  (OperandA),
      .OperandB  (OperandB),
      .DestIn    (DestIn),
      .Busy      (Busy),
      .RegWrite  (RegWrite),
      .RD        (RD),
      .WriteData (WriteData),
      .DivByZero (DivByZero)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Presents one Start for a single edge, then scrambles operands.
   task automatic issue(input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [1:0] d);
      Start    = 1'b1;
      Op       = op;
      OperandA = a;
      OperandB = b;
      DestIn   = d;
      tick();
      Start    = 1'b0;
      Op       = 2'($urandom);
      OperandA = 16'($urandom);
      OperandB = 16'($urandom);
      DestIn   = 2'($urandom);
   endtask

   // Edges counted from the cycle after the Start edge up to RegWrite.
   task automatic await(input string tag, input int exp_wait,
                        input logic [1:0] exp_rd,
                        input logic [15:0] exp_data,
                        input logic exp_dz);
      int  n;
      bit  busy_ok;
      n = 0;
      busy_ok = 1'b1;
      while (!RegWrite && n < 40) begin
         if (!Busy) busy_ok = 1'b0;
         tick();
         n++;
      end
      if (!Busy) busy_ok = 1'b0;
      check({tag, " latency"}, n, exp_wait);
      check({tag, " busy"}, 32'(busy_ok), 1);
      check({tag, " rd"}, RD, exp_rd);
      check({tag, " data"}, WriteData, exp_data);
      check({tag, " dz"}, DivByZero, exp_dz);
      tick();
      check({tag, " strobe_end"}, {Busy, RegWrite, DivByZero}, 0);
      check({tag, " hold"}, WriteData, exp_data);
   endtask

   initial begin
      int wr_cnt;
      Reset = 1'b1;
      Start = 1'b0;
      Op = 2'd0;
      OperandA = '0;
      OperandB = '0;
      DestIn = '0;
      tick();
      tick();
      check("reset_ctrl", {Busy, RegWrite, DivByZero}, 0);
      check("reset_rd", RD, 0);
      check("reset_data", WriteData, 0);
      Reset = 1'b0;
      tick();

      issue(2'b00, 16'd300, 16'd200, 2'd2);
      await("mul300x200", 16, 2'd2, 16'hEA60, 1'b0);

      issue(2'b00, 16'hFFFF, 16'hFFFF, 2'd1);
      await("mulff_lo", 16, 2'd1, 16'h0001, 1'b0);
      issue(2'b01, 16'hFFFF, 16'hFFFF, 2'd1);
      await("mulff_hi", 16, 2'd1, 16'hFFFE, 1'b0);

      issue(2'b10, 16'd100, 16'd7, 2'd3);
      await("div100_7", 16, 2'd3, 16'd14, 1'b0);
      issue(2'b11, 16'd100, 16'd7, 2'd3);
      await("rem100_7", 16, 2'd3, 16'd2, 1'b0);

      issue(2'b10, 16'd1234, 16'd0, 2'd2);
      await("div0_q", 0, 2'd2, 16'hFFFF, 1'b1);
      issue(2'b11, 16'd1234, 16'd0, 2'd1);
      await("div0_r", 0, 2'd1, 16'd1234, 1'b1);

      // Second Start five cycles into a MUL must be ignored.
      issue(2'b00, 16'd5, 16'd6, 2'd1);
      tick();
      tick();
      tick();
      tick();
      Start    = 1'b1;
      Op       = 2'b01;
      OperandA = 16'd9;
      OperandB = 16'd9;
      DestIn   = 2'd3;
      tick();
      Start    = 1'b0;
      await("collide", 11, 2'd1, 16'd30, 1'b0);
      wr_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         if (RegWrite) wr_cnt++;
         tick();
      end
      check("collide_extra_wr", wr_cnt, 0);

      // Back-to-back: Start in the first IDLE cycle after DONE.
      issue(2'b00, 16'd7, 16'd8, 2'd2);
      await("b2b_first", 16, 2'd2, 16'd56, 1'b0);
      issue(2'b10, 16'd50, 16'd6, 2'd0);
      await("b2b_second", 16, 2'd0, 16'd8, 1'b0);

      // Reset five cycles after a DIV Start aborts it.
      issue(2'b10, 16'd100, 16'd7, 2'd2);
      tick();
      tick();
      tick();
      tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("abort_busy", {Busy, RegWrite}, 0);
      wr_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         if (RegWrite) wr_cnt++;
         tick();
      end
      check("abort_no_wr", wr_cnt, 0);
      issue(2'b00, 16'd3, 16'd4, 2'd1);
      await("after_abort", 16, 2'd1, 16'd12, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
